xor_pio_cmd_master: RTL and testbench

FPGA-side initiator for the PIO command protocol used between the HPS and the fixed-point XOR network. It accepts one signed input vector (x1, x2) over a valid/ready handshake and issues the command-word writes that load and start the network. It then polls the network output until it equals the done value, reads back the cycle count, and returns the result over a second valid/ready handshake. It drives the same command/data/response buses that the HPS normally drives through pp_out_lw_axi, pp_out_axi and pp_in_axi, for hardware self-test and HPS-free benchmarking.

---
 rtl/xor_pio_cmd_master.sv | 215 +++++++++++++++++++++
 tb/tb_xor_pio_cmd_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_pio_cmd_master.sv
// xor_pio_cmd_master
// FPGA-side initiator for the HPS <-> XOR-network PIO command protocol.
// It takes one (x1, x2) vector, writes it to the responder (addr0 clears the
// network, addr1 starts it), then polls addr0 until the network output equals
// DONE_VAL. It reads the cycle count from addr1 and returns the result.
//
// Optional feature macro: XOR_PIO_MASTER_TIMEOUT_EN
//   defined   -> polling aborts after TIMEOUT poll cycles with res_timeout=1.
//   undefined -> polling waits indefinitely and res_timeout is tied low.
module xor_pio_cmd_master #(
    parameter int                 RD_LAT   = 2,
    parameter logic signed [15:0] DONE_VAL = 16'sd1024,
    parameter int                 TIMEOUT  = 4096
) (
    input  logic               CLOCK1_50,
    input  logic               reset,
    input  logic               vec_valid,
    output logic               vec_ready,
    input  logic signed [15:0] vec_x1,
    input  logic signed [15:0] vec_x2,
    output logic [31:0]        cmd_word,
    output logic [31:0]        cmd_data,
    input  logic [31:0]        rsp_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [15:0]        res_out,
    output logic [31:0]        res_count,
    output logic               res_timeout
);

    // Command words: [31]=0, [30]=we, [29:20]=regNum, [19:0]=address.
    localparam logic [31:0] CMD_IDLE = 32'h3FF0_0000;
    localparam logic [31:0] CMD_WR0  = 32'h4000_0000;
    localparam logic [31:0] CMD_WR1  = 32'h4000_0001;
    localparam logic [31:0] CMD_RD0  = 32'h0000_0000;
    localparam logic [31:0] CMD_RD1  = 32'h0000_0001;

    localparam int WAIT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_WR1,
        S_POLL,
        S_CNT,
        S_RESP
    } state_t;

    state_t             state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic signed [15:0] x2_q, x2_nxt;
    logic [31:0]        cmd_word_nxt, cmd_data_nxt;
    logic               res_valid_nxt;
    logic [15:0]        res_out_nxt;
    logic [31:0]        res_count_nxt;
    logic               poll_sample;
    logic               hit_done;
    logic               timeout_hit;
    logic               vec_take;

    // The wait counter reaching RD_LAT marks the cycle where rsp_data answers
    // the read command that has been held on cmd_word.
    assign poll_sample = (wait_cnt == WAIT_W'(RD_LAT));
    assign hit_done    = ($signed(rsp_data[15:0]) == DONE_VAL);
    // vec_ready is low for one cycle after reset even though state is IDLE.
    assign vec_take    = (state == S_IDLE) && vec_valid && vec_ready;

`ifdef XOR_PIO_MASTER_TIMEOUT_EN
    localparam int POLL_W = $clog2(TIMEOUT + 1);

    logic [POLL_W-1:0] poll_cnt, poll_nxt;
    logic              res_timeout_q, res_timeout_nxt;

    assign timeout_hit = (poll_cnt >= POLL_W'(TIMEOUT));
    assign res_timeout = res_timeout_q;

    // Poll-cycle counter and timeout flag next-state.
    always_comb begin
        poll_nxt        = poll_cnt;
        res_timeout_nxt = res_timeout_q;
        if (state == S_WR1) begin
            poll_nxt = '0;
        end else if (state == S_POLL) begin
            poll_nxt = poll_cnt + POLL_W'(1);
        end
        if (vec_take) begin
            res_timeout_nxt = 1'b0;
        end else if (state == S_POLL && timeout_hit && !(poll_sample && hit_done)) begin
            res_timeout_nxt = 1'b1;
        end
    end

    // Poll-cycle counter and timeout flag registers.
    always_ff @(posedge CLOCK1_50) begin
        if (reset) begin
            poll_cnt      <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            poll_cnt      <= poll_nxt;
            res_timeout_q <= res_timeout_nxt;
        end
    end
`else
    // TIMEOUT only matters when the abort logic is built.
    logic unused_timeout;
    assign unused_timeout = TIMEOUT[0];
    assign timeout_hit    = 1'b0;
    assign res_timeout    = 1'b0;
`endif

    // Next-state and next-output decode; outputs are registered from these.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        x2_nxt        = x2_q;
        cmd_word_nxt  = CMD_IDLE;
        cmd_data_nxt  = '0;
        res_valid_nxt = 1'b0;
        res_out_nxt   = res_out;
        res_count_nxt = res_count;

        case (state)
            S_IDLE: begin
                if (vec_take) begin
                    // x1 goes straight into cmd_data; only x2 is needed a cycle later.
                    state_nxt    = S_WR0;
                    cmd_word_nxt = CMD_WR0;
                    cmd_data_nxt = 32'(vec_x1);
                    x2_nxt       = vec_x2;
                end
            end
            S_WR0: begin
                state_nxt    = S_WR1;
                cmd_word_nxt = CMD_WR1;
                cmd_data_nxt = 32'(x2_q);
            end
            S_WR1: begin
                state_nxt    = S_POLL;
                cmd_word_nxt = CMD_RD0;
                wait_nxt     = '0;
            end
            S_POLL: begin
                cmd_word_nxt = CMD_RD0;
                wait_nxt     = wait_cnt + WAIT_W'(1);
                if (poll_sample) begin
                    res_out_nxt = rsp_data[15:0];
                    if (hit_done) begin
                        state_nxt    = S_CNT;
                        cmd_word_nxt = CMD_RD1;
                        wait_nxt     = '0;
                    end else begin
                        // The read stays on the bus, so later samples are already
                        // RD_LAT apart: restart just past the entry cycle.
                        wait_nxt = WAIT_W'(1);
                    end
                end
                // A match on the limit cycle takes priority over the abort.
                if (timeout_hit && !(poll_sample && hit_done)) begin
                    state_nxt     = S_RESP;
                    cmd_word_nxt  = CMD_IDLE;
                    res_valid_nxt = 1'b1;
                    res_count_nxt = '1;
                end
            end
            S_CNT: begin
                cmd_word_nxt = CMD_RD1;
                wait_nxt     = wait_cnt + WAIT_W'(1);
                if (poll_sample) begin
                    state_nxt     = S_RESP;
                    cmd_word_nxt  = CMD_IDLE;
                    res_valid_nxt = 1'b1;
                    res_count_nxt = rsp_data;
                end
            end
            S_RESP: begin
                res_valid_nxt = 1'b1;
                if (res_ready) begin
                    state_nxt     = S_IDLE;
                    res_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset aborts any operation.
    always_ff @(posedge CLOCK1_50) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            x2_q      <= '0;
            cmd_word  <= CMD_IDLE;
            cmd_data  <= '0;
            vec_ready <= 1'b0;
            res_valid <= 1'b0;
            res_out   <= '0;
            res_count <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            x2_q      <= x2_nxt;
            cmd_word  <= cmd_word_nxt;
            cmd_data  <= cmd_data_nxt;
            vec_ready <= (state_nxt == S_IDLE);
            res_valid <= res_valid_nxt;
            res_out   <= res_out_nxt;
            res_count <= res_count_nxt;
        end
    end

endmodule

// File: tb/tb_xor_pio_cmd_master.sv
// tb_xor_pio_cmd_master
// Table-driven bench for xor_pio_cmd_master with a cycle-level responder model.
// Build with XOR_PIO_MASTER_TIMEOUT_EN defined to exercise the poll abort
// (TIMEOUT=64); the default build runs a long 10000-cycle completion instead.
module tb_xor_pio_cmd_master;

    localparam int                 RD_LAT     = 2;
    localparam logic signed [15:0] DONE_VAL   = 16'sd1024;
    localparam int                 TB_TIMEOUT = 64;
    localparam int                 LAT_BOUND  = 30000;

    localparam logic [31:0] IDLE_CMD = 32'h3FF00000;
    localparam logic [31:0] WR0_CMD  = 32'h40000000;
    localparam logic [31:0] WR1_CMD  = 32'h40000001;
    localparam logic [31:0] RD0_CMD  = 32'h00000000;
    localparam logic [31:0] RD1_CMD  = 32'h00000001;

    logic               CLOCK1_50 = 1'b0;
    logic               reset;
    logic               vec_valid;
    logic               vec_ready;
    logic signed [15:0] vec_x1;
    logic signed [15:0] vec_x2;
    logic [31:0]        cmd_word;
    logic [31:0]        cmd_data;
    logic [31:0]        rsp_data;
    logic               res_valid;
    logic               res_ready;
    logic [15:0]        res_out;
    logic [31:0]        res_count;
    logic               res_timeout;

    always #5 CLOCK1_50 = ~CLOCK1_50;

    xor_pio_cmd_master #(
        .RD_LAT  (RD_LAT),
        .DONE_VAL(DONE_VAL),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .CLOCK1_50  (CLOCK1_50),
        .reset      (reset),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_x1     (vec_x1),
        .vec_x2     (vec_x2),
        .cmd_word   (cmd_word),
        .cmd_data   (cmd_data),
        .rsp_data   (rsp_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_out    (res_out),
        .res_count  (res_count),
        .res_timeout(res_timeout)
    );

    // ---------------- responder model ----------------
    // Network output becomes DONE_VAL once done_after cycles have elapsed since
    // the addr1 write started it; addr1 reads return count_val. Read data shows
    // up RD_LAT cycles after the command.
    int          cyc        = 0;
    logic        started    = 1'b0;
    int          start_cyc  = 0;
    int          rd1_count  = 0;
    int          done_after = 0;
    logic [31:0] count_val  = '0;
    logic [15:0] fill_val   = '0;
    logic [31:0] rd_val;
    logic [31:0] rsp_pipe [RD_LAT];

    always_comb begin
        rd_val = 32'h0;
        if (cmd_word == RD0_CMD) begin
            rd_val = (started && (cyc - start_cyc >= done_after)) ? {16'h0, DONE_VAL}
                                                                  : {16'h0, fill_val};
        end else if (cmd_word == RD1_CMD) begin
            rd_val = count_val;
        end
    end

    always @(posedge CLOCK1_50) begin
        cyc <= cyc + 1;
        if (cmd_word == WR0_CMD) started <= 1'b0;
        if (cmd_word == WR1_CMD) begin
            started   <= 1'b1;
            start_cyc <= cyc;
        end
        if (cmd_word == RD1_CMD) rd1_count <= rd1_count + 1;
        rsp_pipe[0] <= rd_val;
        for (int i = 1; i < RD_LAT; i++) rsp_pipe[i] <= rsp_pipe[i-1];
    end

    assign rsp_data = rsp_pipe[RD_LAT-1];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK1_50);
        #1;
    endtask

    typedef struct {
        logic signed [15:0] x1;
        logic signed [15:0] x2;
        int                 done_after;
        logic [31:0]        count_val;
        logic [15:0]        fill;
        logic [15:0]        exp_out;
        logic [31:0]        exp_count;
        logic               exp_to;
        int                 exp_lat;   // cycles from handshake to res_valid
    } vec_rec_t;

    // Reference model from the protocol timing: first read at T+3, each compare
    // sees the network value from RD_LAT (=2) cycles earlier, which is 1+2k
    // cycles after start on the k-th extra poll. So the matching compare is at
    // poll index 2+2k with k=done_after/2; CNT then takes 3 cycles and res_valid
    // follows one cycle later.
    function automatic vec_rec_t with_expect(input vec_rec_t r);
        vec_rec_t o;
        int       p_match;
        o       = r;
        p_match = 2 + 2 * (r.done_after / 2);
        o.exp_out   = DONE_VAL;
        o.exp_count = r.count_val;
        o.exp_to    = 1'b0;
        o.exp_lat   = p_match + 7;
`ifdef XOR_PIO_MASTER_TIMEOUT_EN
        if (p_match > TB_TIMEOUT) begin
            o.exp_out   = r.fill;
            o.exp_count = 32'hFFFFFFFF;
            o.exp_to    = 1'b1;
            o.exp_lat   = TB_TIMEOUT + 4;
        end
`endif
        return o;
    endfunction

    function automatic vec_rec_t mk(input logic signed [15:0] x1, input logic signed [15:0] x2,
                                    input int d, input logic [31:0] cnt, input logic [15:0] fill);
        vec_rec_t r;
        r.x1 = x1; r.x2 = x2; r.done_after = d; r.count_val = cnt; r.fill = fill;
        r.exp_out = '0; r.exp_count = '0; r.exp_to = 1'b0; r.exp_lat = 0;
        return with_expect(r);
    endfunction

    // Offer one vector, follow it to the result, optionally stall res_ready.
    task automatic run_vec(input int idx, input vec_rec_t r, input int hold);
        int    w;
        int    lat;
        int    rd1_before;
        string tag;
        tag        = $sformatf("v%0d", idx);
        done_after = r.done_after;
        count_val  = r.count_val;
        fill_val   = r.fill;
        rd1_before = rd1_count;
        vec_x1     = r.x1;
        vec_x2     = r.x2;
        vec_valid  = 1'b1;
        w = 0;
        while (!vec_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, " vec_ready before accept"}, 32'(vec_ready), 32'd1);
        tick();                 // handshake edge; now cycle T+1
        vec_valid = 1'b0;
        vec_x1    = 16'h5A5A;
        vec_x2    = 16'hA5A5;
        check({tag, " T+1 cmd_word"}, cmd_word, WR0_CMD);
        check({tag, " T+1 cmd_data"}, cmd_data, 32'(int'(r.x1)));
        check({tag, " T+1 vec_ready"}, 32'(vec_ready), 32'd0);
        tick();
        check({tag, " T+2 cmd_word"}, cmd_word, WR1_CMD);
        check({tag, " T+2 cmd_data"}, cmd_data, 32'(int'(r.x2)));
        tick();
        check({tag, " T+3 cmd_word"}, cmd_word, RD0_CMD);
        lat = 3;
        while (!res_valid && lat < LAT_BOUND) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(r.exp_lat));
        check({tag, " res_out"}, 32'(res_out), 32'(r.exp_out));
        check({tag, " res_count"}, res_count, r.exp_count);
        check({tag, " res_timeout"}, 32'(res_timeout), 32'(r.exp_to));
        check({tag, " idle cmd in RESP"}, cmd_word, IDLE_CMD);
        if (r.exp_to) check({tag, " addr1 reads"}, 32'(rd1_count - rd1_before), 32'd0);
        // Stall the result with a competing vector offered; nothing may move.
        vec_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check($sformatf("%s hold%0d res_valid", tag, i), 32'(res_valid), 32'd1);
            check($sformatf("%s hold%0d res_out", tag, i), 32'(res_out), 32'(r.exp_out));
            check($sformatf("%s hold%0d res_count", tag, i), res_count, r.exp_count);
            check($sformatf("%s hold%0d vec_ready", tag, i), 32'(vec_ready), 32'd0);
            check($sformatf("%s hold%0d cmd_word", tag, i), cmd_word, IDLE_CMD);
        end
        vec_valid = 1'b0;
        res_ready = 1'b1;
        tick();                 // result handshake edge
        res_ready = 1'b0;
        check({tag, " res_valid after handshake"}, 32'(res_valid), 32'd0);
        check({tag, " vec_ready after handshake"}, 32'(vec_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_rec_t tbl[$];
        vec_rec_t normal;

        for (int i = 0; i < RD_LAT; i++) rsp_pipe[i] = '0;

        // ---- vector table ----
        normal = mk(16'sd1024, 16'sd0, 5, 32'd7, 16'd0);   // matches on the 3rd poll
        tbl.push_back(normal);
        tbl.push_back(mk(-16'sd1024, -16'sd1, 0, 32'h12345678, 16'd100));
        tbl.push_back(mk(16'sh7FFF, -16'sh8000, 1, 32'h0, 16'd1023));
`ifdef XOR_PIO_MASTER_TIMEOUT_EN
        tbl.push_back(mk(16'sd3, 16'sd4, 1 << 30, 32'd55, 16'd0));   // never matches
        tbl.push_back(mk(16'sd5, 16'sd6, 62, 32'd99, 16'd17));       // match on limit cycle
        tbl.push_back(mk(16'sd7, 16'sd8, 64, 32'd98, 16'd5));        // one poll too late
`else
        tbl.push_back(mk(16'sd9, -16'sd9, 10000, 32'hCAFE0001, 16'd3));
`endif
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(16'($urandom), 16'($urandom), int'($urandom_range(0, 40)),
                             32'($urandom), 16'($urandom_range(0, 1023))));
        end

        // ---- reset state ----
        reset     = 1'b1;
        vec_valid = 1'b0;
        vec_x1    = '0;
        vec_x2    = '0;
        res_ready = 1'b0;
        repeat (3) tick();
        check("reset cmd_word", cmd_word, IDLE_CMD);
        check("reset cmd_data", cmd_data, 32'h0);
        check("reset vec_ready", 32'(vec_ready), 32'd0);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset res_out", 32'(res_out), 32'd0);
        check("reset res_count", res_count, 32'd0);
        check("reset res_timeout", 32'(res_timeout), 32'd0);
        reset = 1'b0;
        tick();
        check("vec_ready after reset", 32'(vec_ready), 32'd1);

        // ---- table run; first entry also gets 10 cycles of backpressure ----
        foreach (tbl[i]) run_vec(i, tbl[i], (i == 0) ? 10 : 0);

        // ---- reset while polling ----
        done_after = normal.done_after;
        count_val  = normal.count_val;
        fill_val   = normal.fill;
        vec_x1     = normal.x1;
        vec_x2     = normal.x2;
        vec_valid  = 1'b1;
        tick();                 // vec_ready is high here, so this is the handshake edge
        vec_valid = 1'b0;
        repeat (3) tick();      // T+4: inside POLL
        check("mid-poll cmd_word", cmd_word, RD0_CMD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post-reset cmd_word", cmd_word, IDLE_CMD);
        check("post-reset res_valid", 32'(res_valid), 32'd0);
        check("post-reset vec_ready", 32'(vec_ready), 32'd0);
        tick();
        check("post-reset vec_ready next", 32'(vec_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("no partial result %0d", i), 32'(res_valid), 32'd0);
        end
        run_vec(99, normal, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
